// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_regfile
// Description : I2C target with an auto-incrementing pointer into a file of
//               NUM_REGS 8-bit registers. Bytes written over the bus are
//               mirrored on regs_flat, and each committed byte raises a
//               one-cycle write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h55,
    parameter int         NUM_REGS   = 4,
    parameter int         PTR_W      = 2,
    parameter logic [7:0] RESET_VAL  = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCL,
    inout  wire                   SDA,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [PTR_W-1:0]      wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    localparam logic [PTR_W-1:0] c_PTR_MAX = PTR_W'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8,
        S_IGNORE    = 4'd9
    } state_t;

    state_t             state_q;
    logic [1:0]         scl_sync_q;
    logic [1:0]         sda_sync_q;
    logic               scl_prev_q;
    logic               sda_prev_q;
    logic [7:0]         shreg_q;
    logic [3:0]         bitcnt_q;
    logic               ack_q;
    logic               sda_oe_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [7:0]         regs_q [NUM_REGS];
    logic               wr_strobe_q;
    logic [PTR_W-1:0]   wr_addr_q;
    logic [7:0]         wr_data_q;

    logic               scl_w;
    logic               sda_w;
    logic               scl_rise_w;
    logic               scl_fall_w;
    logic               start_w;
    logic               stop_w;
    logic [PTR_W-1:0]   ptr_inc_d;
    logic [PTR_W-1:0]   ptr_load_d;

    // Synchronised bus levels and the events derived from them
    assign scl_w      = scl_sync_q[1];
    assign sda_w      = sda_sync_q[1];
    assign scl_rise_w = scl_w & ~scl_prev_q;
    assign scl_fall_w = ~scl_w & scl_prev_q;
    assign start_w    = scl_w & scl_prev_q & sda_prev_q & ~sda_w;
    assign stop_w     = scl_w & scl_prev_q & ~sda_prev_q & sda_w;

    // Pointer wraps at NUM_REGS-1 so non-power-of-two sizes stay in range
    assign ptr_inc_d  = (ptr_q == c_PTR_MAX) ? '0 : ptr_q + 1'b1;
    assign ptr_load_d = PTR_W'({1'b0, shreg_q} % 9'(NUM_REGS));

    // Open-drain pad: only ever pull low or release
    assign SDA       = sda_oe_q ? 1'b0 : 1'bz;
    assign busy      = (state_q != S_IDLE);
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_flat[gi*8 +: 8] = regs_q[gi];
        end
    endgenerate

    // Synchronisers, protocol FSM, register file and strobe outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            scl_sync_q  <= 2'b11;
            sda_sync_q  <= 2'b11;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            ack_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
            ptr_q       <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            scl_sync_q  <= {scl_sync_q[0], SCL};
            sda_sync_q  <= {sda_sync_q[0], SDA};
            scl_prev_q  <= scl_w;
            sda_prev_q  <= sda_w;
            wr_strobe_q <= 1'b0;

            if (start_w) begin
                // Any START, repeated or not, restarts address reception
                state_q  <= S_ADDR;
                bitcnt_q <= '0;
                sda_oe_q <= 1'b0;
            end else if (stop_w) begin
                state_q  <= S_IDLE;
                bitcnt_q <= '0;
                sda_oe_q <= 1'b0;
            end else if (scl_rise_w) begin
                case (state_q)
                    S_ADDR, S_PTR, S_WDATA: begin
                        shreg_q  <= {shreg_q[6:0], sda_w};
                        bitcnt_q <= bitcnt_q + 4'd1;
                    end
                    S_RDATA:     bitcnt_q <= bitcnt_q + 4'd1;
                    S_RDATA_ACK: ack_q    <= sda_w;
                    default: ;
                endcase
            end else if (scl_fall_w) begin
                case (state_q)
                    S_ADDR: begin
                        if (bitcnt_q == 4'd8) begin
                            bitcnt_q <= '0;
                            if (shreg_q[7:1] == SLAVE_ADDR) begin
                                state_q  <= S_ADDR_ACK;
                                sda_oe_q <= 1'b1;
                            end else begin
                                state_q  <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        bitcnt_q <= '0;
                        // shreg still holds the address byte; bit 0 is R/W
                        if (shreg_q[0]) begin
                            shreg_q  <= regs_q[ptr_q];
                            sda_oe_q <= ~regs_q[ptr_q][7];
                            state_q  <= S_RDATA;
                        end else begin
                            sda_oe_q <= 1'b0;
                            state_q  <= S_PTR;
                        end
                    end
                    S_PTR: begin
                        if (bitcnt_q == 4'd8) begin
                            bitcnt_q <= '0;
                            ptr_q    <= ptr_load_d;
                            sda_oe_q <= 1'b1;
                            state_q  <= S_PTR_ACK;
                        end
                    end
                    S_PTR_ACK: begin
                        sda_oe_q <= 1'b0;
                        state_q  <= S_WDATA;
                    end
                    S_WDATA: begin
                        if (bitcnt_q == 4'd8) begin
                            bitcnt_q       <= '0;
                            regs_q[ptr_q]  <= shreg_q;
                            wr_strobe_q    <= 1'b1;
                            wr_addr_q      <= ptr_q;
                            wr_data_q      <= shreg_q;
                            ptr_q          <= ptr_inc_d;
                            sda_oe_q       <= 1'b1;
                            state_q        <= S_WDATA_ACK;
                        end
                    end
                    S_WDATA_ACK: begin
                        sda_oe_q <= 1'b0;
                        state_q  <= S_WDATA;
                    end
                    S_RDATA: begin
                        if (bitcnt_q == 4'd8) begin
                            bitcnt_q <= '0;
                            sda_oe_q <= 1'b0;
                            ptr_q    <= ptr_inc_d;
                            state_q  <= S_RDATA_ACK;
                        end else begin
                            shreg_q  <= {shreg_q[6:0], 1'b0};
                            sda_oe_q <= ~shreg_q[6];
                        end
                    end
                    S_RDATA_ACK: begin
                        if (!ack_q) begin
                            shreg_q  <= regs_q[ptr_q];
                            sda_oe_q <= ~regs_q[ptr_q][7];
                            state_q  <= S_RDATA;
                        end else begin
                            state_q  <= S_IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
